// File: rtl/host_arbiter_pkg.sv
// Shared widths, host-index defines and helpers for the multi-host arbiter.
// Bus widths fall back to 32 bits when the system defines are not already present.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef HOST_CORE_PORT
`define HOST_CORE_PORT 0
`endif
`ifndef HOST_DMA_PORT
`define HOST_DMA_PORT 1
`endif

package host_arbiter_pkg;

   // Next index after idx, wrapping at n.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/host_arbiter_rr_pick.sv
// Combinational find-first-set over req_i, scanning from ptr_i upward with wrap-around.
module rr_pick
   import host_arbiter_pkg::*;
#(
   parameter int unsigned N = 2,
   parameter int unsigned W = 1
) (
   input  logic         req_i [N],
   input  logic [W-1:0] ptr_i,
   output logic         valid_o,
   output logic [W-1:0] idx_o
);

   always_comb begin
      int j;
      valid_o = 1'b0;
      idx_o   = '0;
      j       = 0;
      // Scan from the far end back toward ptr so the nearest requester is written last.
      for (int k = int'(N) - 1; k >= 0; k--) begin
         j = int'(ptr_i) + k;
         if (j >= int'(N)) j = j - int'(N);
         if (req_i[j]) begin
            valid_o = 1'b1;
            idx_o   = W'(j);
         end
      end
   end

endmodule

// File: rtl/host_arbiter.sv
// Round-robin front end sharing one downstream bus port among NrHosts masters,
// with bounded locked bursts and read-response steering back to the issuing host.
module host_arbiter
   import host_arbiter_pkg::*;
#(
   parameter int unsigned NrHosts      = 2,
   parameter int unsigned DataWidth    = `DATA_WIDTH,
   parameter int unsigned AddressWidth = `ADDR_WIDTH,
   parameter int unsigned MaxHold      = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    host_req_i    [NrHosts],
   input  logic                    host_lock_i   [NrHosts],
   input  logic [AddressWidth-1:0] host_addr_i   [NrHosts],
   input  logic                    host_we_i     [NrHosts],
   input  logic [DataWidth-1:0]    host_wdata_i  [NrHosts],
   output logic                    host_gnt_o    [NrHosts],
   output logic                    host_rvalid_o [NrHosts],
   output logic [DataWidth-1:0]    host_rdata_o  [NrHosts],
   output logic                    bus_req_o,
   output logic [AddressWidth-1:0] bus_addr_o,
   output logic                    bus_we_o,
   output logic [DataWidth-1:0]    bus_wdata_o,
   input  logic                    bus_gnt_i,
   input  logic [DataWidth-1:0]    bus_rdata_i
);

   localparam int unsigned PtrW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
   localparam int unsigned CntW = $clog2(MaxHold) + 1;
   localparam logic [CntW-1:0] HoldLast = CntW'(MaxHold - 1);

   logic [PtrW-1:0] ptr_q, ptr_d;
   logic            locked_q, locked_d;
   logic [PtrW-1:0] owner_q, owner_d;
   logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
   logic            resp_pend_q, resp_pend_d;
   logic [PtrW-1:0] resp_idx_q, resp_idx_d;

   logic            pick_valid;
   logic [PtrW-1:0] pick_idx;
   logic            lock_hold;
   logic            any_req;
   logic [PtrW-1:0] winner;
   logic            accept;
   logic [CntW-1:0] cnt_eff;

   rr_pick #(.N(NrHosts), .W(PtrW)) u_pick (
      .req_i   (host_req_i),
      .ptr_i   (ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   // A lock only holds while its owner keeps requesting; otherwise fall back to round-robin.
   assign lock_hold = locked_q & host_req_i[owner_q];
   assign winner    = lock_hold ? owner_q : pick_idx;
   assign any_req   = lock_hold | pick_valid;
   assign accept    = bus_req_o & bus_gnt_i;
   assign cnt_eff   = lock_hold ? hold_cnt_q : '0;

   always_comb begin
      bus_req_o   = rst_i & any_req;
      bus_addr_o  = '0;
      bus_we_o    = 1'b0;
      bus_wdata_o = '0;
      if (any_req) begin
         bus_addr_o  = host_addr_i[winner];
         bus_we_o    = host_we_i[winner];
         bus_wdata_o = host_wdata_i[winner];
      end
   end

   generate
      for (genvar gi = 0; gi < NrHosts; gi++) begin : g_host
         assign host_gnt_o[gi]    = accept & (winner == PtrW'(gi));
         assign host_rvalid_o[gi] = rst_i & resp_pend_q & (resp_idx_q == PtrW'(gi));
         assign host_rdata_o[gi]  = bus_rdata_i;
      end
   endgenerate

   always_comb begin
      ptr_d       = ptr_q;
      locked_d    = lock_hold;
      owner_d     = owner_q;
      hold_cnt_d  = cnt_eff;
      resp_pend_d = 1'b0;
      resp_idx_d  = resp_idx_q;
      if (accept) begin
         // hold_cnt counts beats already taken, so the MaxHold-th beat releases the lock.
         if (host_lock_i[winner] && (cnt_eff < HoldLast)) begin
            locked_d   = 1'b1;
            owner_d    = winner;
            hold_cnt_d = cnt_eff + CntW'(1);
         end else begin
            locked_d   = 1'b0;
            hold_cnt_d = '0;
            ptr_d      = PtrW'(wrap_inc(32'(winner), NrHosts));
         end
         resp_pend_d = ~host_we_i[winner];
         resp_idx_d  = winner;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ptr_q       <= '0;
         locked_q    <= 1'b0;
         owner_q     <= '0;
         hold_cnt_q  <= '0;
         resp_pend_q <= 1'b0;
         resp_idx_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         locked_q    <= locked_d;
         owner_q     <= owner_d;
         hold_cnt_q  <= hold_cnt_d;
         resp_pend_q <= resp_pend_d;
         resp_idx_q  <= resp_idx_d;
      end
   end

endmodule

// File: tb/tb_host_arbiter.sv
// Directed bench for host_arbiter with two hosts and MaxHold=4; expected values hand-computed.
module tb_host_arbiter;

   localparam int unsigned N  = 2;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          host_req_i    [N];
   logic          host_lock_i   [N];
   logic [AW-1:0] host_addr_i   [N];
   logic          host_we_i     [N];
   logic [DW-1:0] host_wdata_i  [N];
   logic          host_gnt_o    [N];
   logic          host_rvalid_o [N];
   logic [DW-1:0] host_rdata_o  [N];
   logic          bus_req_o;
   logic [AW-1:0] bus_addr_o;
   logic          bus_we_o;
   logic [DW-1:0] bus_wdata_o;
   logic          bus_gnt_i;
   logic [DW-1:0] bus_rdata_i;

   logic [1:0] gnt_v;
   logic [1:0] rvalid_v;
   int checks = 0;
   int errors = 0;

   assign gnt_v    = {host_gnt_o[1], host_gnt_o[0]};
   assign rvalid_v = {host_rvalid_o[1], host_rvalid_o[0]};

   always #5 clk_i = ~clk_i;

   host_arbiter #(.NrHosts(N), .DataWidth(DW), .AddressWidth(AW), .MaxHold(4)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .host_req_i    (host_req_i),
      .host_lock_i   (host_lock_i),
      .host_addr_i   (host_addr_i),
      .host_we_i     (host_we_i),
      .host_wdata_i  (host_wdata_i),
      .host_gnt_o    (host_gnt_o),
      .host_rvalid_o (host_rvalid_o),
      .host_rdata_o  (host_rdata_o),
      .bus_req_o     (bus_req_o),
      .bus_addr_o    (bus_addr_o),
      .bus_we_o      (bus_we_o),
      .bus_wdata_o   (bus_wdata_o),
      .bus_gnt_i     (bus_gnt_i),
      .bus_rdata_i   (bus_rdata_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are then changed and sampled mid-cycle.
   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic set_host(input int h, input logic req, input logic lock, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
      host_req_i[h]   = req;
      host_lock_i[h]  = lock;
      host_we_i[h]    = we;
      host_addr_i[h]  = addr;
      host_wdata_i[h] = wdata;
   endtask

   initial begin
      rst_i       = 1'b0;
      bus_gnt_i   = 1'b1;
      bus_rdata_i = '0;
      set_host(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
      set_host(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

      // Reset held three edges with host 0 requesting.
      #1;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) next_cycle();
         settle();
         chk("rst_bus_req", 32'(bus_req_o), 32'h0);
         chk("rst_gnt", 32'(gnt_v), 32'h0);
      end

      // Single read from host 0.
      next_cycle();
      rst_i = 1'b1;
      settle();
      chk("rd0_gnt", 32'(gnt_v), 32'h1);
      chk("rd0_bus_req", 32'(bus_req_o), 32'h1);
      chk("rd0_addr", bus_addr_o, 32'h100);
      chk("rd0_we", 32'(bus_we_o), 32'h0);
      next_cycle();
      set_host(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      bus_rdata_i = 32'hCAFE0001;
      settle();
      chk("rd0_rvalid", 32'(rvalid_v), 32'h1);
      chk("rd0_rdata", host_rdata_o[0], 32'hCAFE0001);
      chk("idle_gnt", 32'(gnt_v), 32'h0);
      chk("idle_bus_req", 32'(bus_req_o), 32'h0);
      chk("idle_addr_zero", bus_addr_o, 32'h0);

      // Round-robin: pointer is 1 after the read, so grants go 1,0,1.
      next_cycle();
      set_host(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'hA0);
      set_host(1, 1'b1, 1'b0, 1'b1, 32'h20, 32'hB1);
      settle();
      chk("rr_gnt_a", 32'(gnt_v), 32'h2);
      chk("rr_addr_a", bus_addr_o, 32'h20);
      chk("rr_wdata_a", bus_wdata_o, 32'hB1);
      chk("rr_no_rvalid_a", 32'(rvalid_v), 32'h0);
      next_cycle();
      settle();
      chk("rr_gnt_b", 32'(gnt_v), 32'h1);
      chk("rr_addr_b", bus_addr_o, 32'h10);
      next_cycle();
      settle();
      chk("rr_gnt_c", 32'(gnt_v), 32'h2);

      // Lock with MaxHold=4: host 0 gets four beats, then host 1.
      next_cycle();
      host_lock_i[0] = 1'b1;
      for (int b = 0; b < 4; b++) begin
         if (b > 0) next_cycle();
         settle();
         chk($sformatf("lock_gnt_%0d", b), 32'(gnt_v), 32'h1);
      end
      next_cycle();
      settle();
      chk("lock_rotate", 32'(gnt_v), 32'h2);

      // Owner drops request after two locked beats; host 1 wins that cycle.
      next_cycle();
      settle();
      chk("drop_gnt_0", 32'(gnt_v), 32'h1);
      next_cycle();
      settle();
      chk("drop_gnt_1", 32'(gnt_v), 32'h1);
      next_cycle();
      set_host(0, 1'b0, 1'b0, 1'b1, 32'h10, 32'hA0);
      settle();
      chk("drop_gnt_h1", 32'(gnt_v), 32'h2);

      // Downstream stall with host 1 winning.
      next_cycle();
      bus_gnt_i = 1'b0;
      for (int s = 0; s < 3; s++) begin
         if (s > 0) next_cycle();
         settle();
         chk($sformatf("stall_gnt_%0d", s), 32'(gnt_v), 32'h0);
         chk($sformatf("stall_req_%0d", s), 32'(bus_req_o), 32'h1);
         chk($sformatf("stall_addr_%0d", s), bus_addr_o, 32'h20);
      end
      next_cycle();
      bus_gnt_i = 1'b1;
      settle();
      chk("stall_release_gnt", 32'(gnt_v), 32'h2);
      next_cycle();
      host_req_i[0] = 1'b1;
      settle();
      chk("stall_ptr0_gnt", 32'(gnt_v), 32'h1);

      // Mixed: host 0 write, then host 1 read back-to-back.
      next_cycle();
      set_host(0, 1'b1, 1'b0, 1'b1, 32'h300000, 32'h5A5A5A5A);
      set_host(1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
      settle();
      chk("mix_wr_gnt", 32'(gnt_v), 32'h1);
      chk("mix_wr_addr", bus_addr_o, 32'h300000);
      chk("mix_wr_we", 32'(bus_we_o), 32'h1);
      chk("mix_wr_wdata", bus_wdata_o, 32'h5A5A5A5A);
      next_cycle();
      set_host(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_host(1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
      settle();
      chk("mix_rd_gnt", 32'(gnt_v), 32'h2);
      chk("mix_wr_no_rvalid", 32'(rvalid_v), 32'h0);
      chk("mix_rd_we", 32'(bus_we_o), 32'h0);
      chk("mix_rd_addr", bus_addr_o, 32'h40);
      next_cycle();
      set_host(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      bus_rdata_i = 32'h12345678;
      settle();
      chk("mix_rd_rvalid", 32'(rvalid_v), 32'h2);
      chk("mix_rd_rdata", host_rdata_o[1], 32'h12345678);

      // Back-to-back reads from different hosts (pointer is 0 now).
      next_cycle();
      set_host(0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
      settle();
      chk("b2b_gnt0", 32'(gnt_v), 32'h1);
      next_cycle();
      set_host(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_host(1, 1'b1, 1'b0, 1'b0, 32'h84, 32'h0);
      settle();
      chk("b2b_gnt1", 32'(gnt_v), 32'h2);
      chk("b2b_rvalid0", 32'(rvalid_v), 32'h1);
      next_cycle();
      set_host(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      settle();
      chk("b2b_rvalid1", 32'(rvalid_v), 32'h2);

      // Reset asserted right after an accepted read suppresses its rvalid.
      next_cycle();
      set_host(0, 1'b1, 1'b0, 1'b0, 32'h90, 32'h0);
      settle();
      chk("rstmid_gnt", 32'(gnt_v), 32'h1);
      next_cycle();
      rst_i = 1'b0;
      settle();
      chk("rstmid_rvalid", 32'(rvalid_v), 32'h0);
      chk("rstmid_gnt_forced", 32'(gnt_v), 32'h0);
      chk("rstmid_bus_req", 32'(bus_req_o), 32'h0);
      next_cycle();
      rst_i = 1'b1;
      set_host(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      settle();
      chk("rstmid_after_rvalid", 32'(rvalid_v), 32'h0);

      next_cycle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
